// File: rtl/regfile_mp_pkg.sv
// Shared types and constants for the RV64 integer register file slice.
// Architectural widths plus the address-width helper used by the file and its scoreboard.
package regfile_mp_pkg;

    localparam int NREGS_RV = 32;

    typedef logic [63:0]                   dword_t;
    typedef logic [$clog2(NREGS_RV)-1:0]   reg_t;

    localparam reg_t REG_ZERO = '0;

    function automatic int addr_w(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared at writeback, wiped on flush.
// Decode looks up each read port; a same-cycle writeback masks busy when bypass is enabled.
import regfile_mp_pkg::*;

module reg_scoreboard #(
    parameter int NREGS  = NREGS_RV,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1,
    parameter int AW     = addr_w(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rs,
    input  logic [NWR-1:0]    wen,
    input  logic [NWR*AW-1:0] rd,
    input  logic              issue_en,
    input  logic [AW-1:0]     issue_rd,
    input  logic              flush,
    output logic [NRD-1:0]    rs_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [NREGS-1:0] wr_hit;

    // NOTE: every always_comb output gets a default before any conditional update, so no latch is inferred.
    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < NWR; i++) begin
            if (wen[i] && int'(rd[i*AW +: AW]) < NREGS)
                wr_hit[rd[i*AW +: AW]] = 1'b1;
        end
    end

    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            if (flush)
                busy_d[r] = 1'b0;
            else if (issue_en && int'(issue_rd) == r && r != 0)
                busy_d[r] = 1'b1;
            else if (wr_hit[r])
                busy_d[r] = 1'b0;
        end
        busy_d[0] = 1'b0;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    always_comb begin
        rs_busy = '0;
        for (int j = 0; j < NRD; j++) begin
            logic [AW-1:0] a;
            a = rs[j*AW +: AW];
            if (a != AW'(REG_ZERO) && int'(a) < NREGS)
                rs_busy[j] = busy_q[a] && !(BYPASS != 0 && !rst && wr_hit[a]);
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port RV64 integer register file: NRD combinational reads, NWR writes, x0 tied to zero,
// optional write->read bypass, and a busy scoreboard for RAW hazard detection at decode.
import regfile_mp_pkg::*;

module regfile_mp #(
    parameter int DATA_W = $bits(dword_t),
    parameter int NREGS  = NREGS_RV,
    parameter int NRD    = 2,
    parameter int NWR    = 1,
    parameter int BYPASS = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NRD*addr_w(NREGS)-1:0] rs,
    output logic [NRD*DATA_W-1:0]        rdata,
    output logic [NRD-1:0]               rs_busy,
    input  logic [NWR-1:0]               wen,
    input  logic [NWR*addr_w(NREGS)-1:0] rd,
    input  logic [NWR*DATA_W-1:0]        wdata,
    input  logic                         issue_en,
    input  logic [addr_w(NREGS)-1:0]     issue_rd,
    input  logic                         flush
);

    localparam int AW = addr_w(NREGS);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];

    // Ascending port order lets the highest-index writer win on an address conflict.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NWR; i++) begin
            if (wen[i] && rd[i*AW +: AW] != AW'(REG_ZERO) && int'(rd[i*AW +: AW]) < NREGS)
                regs_d[rd[i*AW +: AW]] = wdata[i*DATA_W +: DATA_W];
        end
    end

    // NOTE: the storage array is reset because reads must return zero immediately after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rdata = '0;
        for (int j = 0; j < NRD; j++) begin
            logic [AW-1:0] a;
            a = rs[j*AW +: AW];
            if (a != AW'(REG_ZERO) && int'(a) < NREGS) begin
                rdata[j*DATA_W +: DATA_W] = regs_q[a];
                if (BYPASS != 0 && !rst) begin
                    for (int i = 0; i < NWR; i++) begin
                        if (wen[i] && rd[i*AW +: AW] == a)
                            rdata[j*DATA_W +: DATA_W] = wdata[i*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    reg_scoreboard #(
        .NREGS  (NREGS),
        .NRD    (NRD),
        .NWR    (NWR),
        .BYPASS (BYPASS),
        .AW     (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .rs       (rs),
        .wen      (wen),
        .rd       (rd),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .flush    (flush),
        .rs_busy  (rs_busy)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: a bypass and a non-bypass file share stimulus; expectations come from an
// array-based architectural model and are popped by a negedge monitor.
module tb_regfile_mp;

    localparam int NRD = 2;
    localparam int NWR = 2;
    localparam int DW  = 64;
    localparam int AW  = 5;
    localparam int NR  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRD*AW-1:0] rs;
    logic [NWR-1:0]    wen;
    logic [NWR*AW-1:0] rd;
    logic [NWR*DW-1:0] wdata;
    logic              issue_en;
    logic [AW-1:0]     issue_rd;
    logic              flush;
    logic [NRD*DW-1:0] rdata_b, rdata_n;
    logic [NRD-1:0]    busy_b, busy_n;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR), .BYPASS(1)) dut_byp (
        .clk(clk), .rst(rst), .rs(rs), .rdata(rdata_b), .rs_busy(busy_b), .wen(wen), .rd(rd),
        .wdata(wdata), .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush)
    );

    regfile_mp #(.DATA_W(DW), .NREGS(NR), .NRD(NRD), .NWR(NWR), .BYPASS(0)) dut_nob (
        .clk(clk), .rst(rst), .rs(rs), .rdata(rdata_n), .rs_busy(busy_n), .wen(wen), .rd(rd),
        .wdata(wdata), .issue_en(issue_en), .issue_rd(issue_rd), .flush(flush)
    );

    // Staged stimulus for the next cycle
    int          s_rs [NRD];
    bit          s_wen [NWR];
    int          s_rd [NWR];
    logic [63:0] s_wdata [NWR];
    bit          s_issue_en;
    int          s_issue_rd;
    bit          s_flush;

    // Architectural model
    logic [63:0] m_regs [NR];
    bit          m_busy [NR];

    typedef struct packed {
        logic [NRD*DW-1:0] rd_b;
        logic [NRD*DW-1:0] rd_n;
        logic [NRD-1:0]    bz_b;
        logic [NRD-1:0]    bz_n;
    } exp_t;

    exp_t  exp_q [$];
    string tag_q [$];
    int    n_checks = 0;
    int    n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic logic [63:0] exp_read(input int a, input bit byp);
        if (a == 0) return 64'h0;
        if (byp)
            for (int i = NWR - 1; i >= 0; i--)
                if (s_wen[i] && s_rd[i] == a) return s_wdata[i];
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(input int a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp)
            for (int i = 0; i < NWR; i++)
                if (s_wen[i] && s_rd[i] == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic idle();
        for (int j = 0; j < NRD; j++) s_rs[j] = 0;
        for (int i = 0; i < NWR; i++) begin
            s_wen[i] = 1'b0; s_rd[i] = 0; s_wdata[i] = 64'h0;
        end
        s_issue_en = 1'b0; s_issue_rd = 0; s_flush = 1'b0;
    endtask

    task automatic drive_and_expect(input string tag);
        exp_t e;
        for (int j = 0; j < NRD; j++) rs[j*AW +: AW] = AW'(s_rs[j]);
        for (int i = 0; i < NWR; i++) begin
            wen[i]             = s_wen[i];
            rd[i*AW +: AW]     = AW'(s_rd[i]);
            wdata[i*DW +: DW]  = s_wdata[i];
        end
        issue_en = s_issue_en;
        issue_rd = AW'(s_issue_rd);
        flush    = s_flush;
        for (int j = 0; j < NRD; j++) begin
            e.rd_b[j*DW +: DW] = exp_read(s_rs[j], 1'b1);
            e.rd_n[j*DW +: DW] = exp_read(s_rs[j], 1'b0);
            e.bz_b[j]          = exp_busy(s_rs[j], 1'b1);
            e.bz_n[j]          = exp_busy(s_rs[j], 1'b0);
        end
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Architectural effect of one clock edge
    task automatic model_edge();
        for (int a = 1; a < NR; a++) begin
            for (int i = NWR - 1; i >= 0; i--) begin
                if (s_wen[i] && s_rd[i] == a) begin
                    m_regs[a] = s_wdata[i];
                    break;
                end
            end
        end
        if (s_flush) begin
            for (int a = 0; a < NR; a++) m_busy[a] = 1'b0;
        end else begin
            for (int i = 0; i < NWR; i++) if (s_wen[i]) m_busy[s_rd[i]] = 1'b0;
            if (s_issue_en && s_issue_rd != 0) m_busy[s_issue_rd] = 1'b1;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        #1;
        drive_and_expect(tag);
        model_edge();
    endtask

    task automatic reset_mid(input string tag);
        @(posedge clk);
        #1;
        for (int a = 0; a < NR; a++) begin
            m_regs[a] = 64'h0; m_busy[a] = 1'b0;
        end
        drive_and_expect(tag);
        #1 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            for (int j = 0; j < NRD; j++) begin
                check($sformatf("%s rdata_byp[%0d]", t, j), rdata_b[j*DW +: DW], e.rd_b[j*DW +: DW]);
                check($sformatf("%s rdata_nob[%0d]", t, j), rdata_n[j*DW +: DW], e.rd_n[j*DW +: DW]);
                check($sformatf("%s busy_byp[%0d]", t, j), 64'(busy_b[j]), 64'(e.bz_b[j]));
                check($sformatf("%s busy_nob[%0d]", t, j), 64'(busy_n[j]), 64'(e.bz_n[j]));
            end
        end
    end

    initial begin
        rst = 1'b1;
        rs = '0; wen = '0; rd = '0; wdata = '0;
        issue_en = 1'b0; issue_rd = '0; flush = 1'b0;
        for (int a = 0; a < NR; a++) begin
            m_regs[a] = 64'h0; m_busy[a] = 1'b0;
        end
        idle();
        #12 rst = 1'b0;

        // Post-reset state
        idle(); s_rs[0] = 1; s_rs[1] = 31;
        step("reset_state");

        // Same-cycle write and read of x5
        idle(); s_wen[0] = 1'b1; s_rd[0] = 5; s_wdata[0] = 64'hDEAD_BEEF_0000_0001; s_rs[0] = 5;
        step("bypass_w5");
        idle(); s_rs[0] = 5;
        step("after_w5");

        // Two ports hit x7: port 1 wins
        idle(); s_wen[0] = 1'b1; s_wen[1] = 1'b1; s_rd[0] = 7; s_rd[1] = 7;
        s_wdata[0] = 64'h11; s_wdata[1] = 64'h22; s_rs[0] = 7; s_rs[1] = 5;
        step("conflict_w7");
        idle(); s_rs[0] = 7;
        step("after_w7");

        // Writes and issues to x0 are ignored
        idle(); s_wen[0] = 1'b1; s_rd[0] = 0; s_wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF; s_rs[1] = 0;
        s_issue_en = 1'b1; s_issue_rd = 0;
        step("x0_write");
        idle(); s_rs[1] = 0;
        step("x0_after");

        // Busy set, re-issue during writeback, then final writeback
        idle(); s_issue_en = 1'b1; s_issue_rd = 10;
        step("issue_x10");
        idle(); s_rs[0] = 10;
        step("busy_x10");
        idle(); s_wen[0] = 1'b1; s_rd[0] = 10; s_wdata[0] = 64'hA; s_issue_en = 1'b1; s_issue_rd = 10; s_rs[0] = 10;
        step("wb_reissue_x10");
        idle(); s_rs[0] = 10;
        step("still_busy_x10");
        idle(); s_wen[1] = 1'b1; s_rd[1] = 10; s_wdata[1] = 64'hB; s_rs[0] = 10; s_rs[1] = 10;
        step("wb_x10");
        idle(); s_rs[0] = 10;
        step("clear_x10");

        // Flush beats same-cycle issue
        idle(); s_issue_en = 1'b1; s_issue_rd = 3; step("issue_x3");
        idle(); s_issue_en = 1'b1; s_issue_rd = 4; s_rs[0] = 3; step("issue_x4");
        idle(); s_issue_en = 1'b1; s_issue_rd = 9; s_rs[0] = 3; s_rs[1] = 4; step("issue_x9");
        idle(); s_flush = 1'b1; s_issue_en = 1'b1; s_issue_rd = 12; s_rs[0] = 9; s_rs[1] = 7;
        step("flush");
        idle(); s_rs[0] = 12; s_rs[1] = 3; step("post_flush_a");
        idle(); s_rs[0] = 4;  s_rs[1] = 9; step("post_flush_b");

        // Mid-cycle reset with preloaded registers and outstanding producers
        idle(); s_wen[0] = 1'b1; s_rd[0] = 1; s_wdata[0] = 64'h1111;
        s_wen[1] = 1'b1; s_rd[1] = 2; s_wdata[1] = 64'h2222; s_issue_en = 1'b1; s_issue_rd = 3;
        step("preload");
        idle(); s_rs[0] = 1; s_rs[1] = 3; step("preloaded");
        idle(); s_rs[0] = 1; s_rs[1] = 2;
        reset_mid("mid_reset");
        idle(); s_rs[0] = 7; s_rs[1] = 3; step("post_reset");

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            idle();
            for (int i = 0; i < NWR; i++) begin
                s_wen[i]   = ($urandom_range(0, 2) != 0);
                s_rd[i]    = $urandom_range(0, NR - 1);
                s_wdata[i] = {$urandom, $urandom};
            end
            s_issue_en = ($urandom_range(0, 1) != 0);
            s_issue_rd = $urandom_range(0, NR - 1);
            s_flush    = ($urandom_range(0, 15) == 0);
            for (int j = 0; j < NRD; j++) begin
                case ($urandom_range(0, 3))
                    0:       s_rs[j] = s_rd[0];
                    1:       s_rs[j] = s_rd[1];
                    2:       s_rs[j] = s_issue_rd;
                    default: s_rs[j] = $urandom_range(0, NR - 1);
                endcase
            end
            step("random");
        end

        idle();
        @(posedge clk); #1; drive_and_expect("final_idle");
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
